// File: rtl/vend_txn_controller_pkg.sv
// vend_pkg: states, coin units, item codes, price table and
// one-hot helper shared by the vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  localparam logic [1:0] NICKEL = 2'd1;
  localparam logic [1:0] DIME   = 2'd2;

  localparam logic [3:0] ITEM1 = 4'b0001;
  localparam logic [3:0] ITEM2 = 4'b0010;
  localparam logic [3:0] ITEM3 = 4'b0100;
  localparam logic [3:0] ITEM4 = 4'b1000;

  // Price in nickels; non one-hot codes cost nothing
  // because they never reach a price compare that matters.
  function automatic logic [2:0] price_of(
    input logic [3:0] item
  );
    case (item)
      ITEM1:   price_of = 3'd3;
      ITEM2:   price_of = 3'd4;
      ITEM3:   price_of = 3'd5;
      ITEM4:   price_of = 3'd6;
      default: price_of = 3'd0;
    endcase
  endfunction

  function automatic logic is_onehot(
    input logic [3:0] v
  );
    is_onehot = (v != 4'd0) &&
                ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/vend_txn_controller_if.sv
// vend_txn_if: coin, selection, hopper and status signals.
// slave = controller side, master = machine/bench side.
// VEND_AUDIT_EN adds sales_total (16-bit, nickels).
interface vend_txn_if #(
  parameter int CREDIT_W = 4
);
  logic                nickel_in;
  logic                dime_in;
  logic [3:0]          item_number;
  logic                select_valid;
  logic                cancel;
  logic                hopper_ready;
  logic                coin_reject;
  logic                dispense;
  logic [3:0]          item_dispensed;
  logic                nickel_out;
  logic                price_short;
  logic                sel_error;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
`ifdef VEND_AUDIT_EN
  logic [15:0]         sales_total;
`endif

  modport slave (
    input  nickel_in, dime_in, item_number,
    input  select_valid, cancel, hopper_ready,
    output coin_reject, dispense, item_dispensed,
    output nickel_out, price_short, sel_error,
`ifdef VEND_AUDIT_EN
    output sales_total,
`endif
    output busy, credit
  );

  modport master (
    output nickel_in, dime_in, item_number,
    output select_valid, cancel, hopper_ready,
    input  coin_reject, dispense, item_dispensed,
    input  nickel_out, price_short, sel_error,
`ifdef VEND_AUDIT_EN
    input  sales_total,
`endif
    input  busy, credit
  );

endinterface

// File: rtl/vend_txn_controller_timer.sv
// vend_timeout_timer: counts enabled idle cycles; expire_o
// fires on the TIMEOUT_CYCLES-th one. Ports: clock, reset,
// clr_i, en_i, expire_o.
module vend_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMR_W-1:0] LAST =
    TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) cnt_d = '0;
    else if (en_i)         cnt_d = cnt_q + TMR_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vend_txn_controller.sv
// vend_txn_controller: shared-credit vending sequencer with
// cancel, inactivity refund and nickel-by-nickel change.
// Ports: clock, reset (async, high), bus (vend_txn_if.slave).
// VEND_AUDIT_EN adds the saturating sales_total counter.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W       = 4,
  parameter int MAX_CREDIT     = 10,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input logic       clock,
  input logic       reset,
  vend_txn_if.slave bus
);

  typedef logic [CREDIT_W:0] wide_t;
  localparam wide_t MAXW = wide_t'(MAX_CREDIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [3:0]          item_q, item_d;
  logic [3:0]          idisp_q, idisp_d;
  logic rej_q, rej_d, disp_q, disp_d;
  logic nout_q, nout_d, short_q, short_d;
  logic selerr_q, selerr_d, busy_q, busy_d;

  logic  in_credit, any_coin, activity;
  logic  coin_ok, expire;
  wide_t cur_w, coin_w, sum_w, sel_pr_w, vend_pr_w;

  assign in_credit = (state_q == CREDIT);
  assign any_coin  = bus.nickel_in || bus.dime_in;
  // Rejected coins also count as customer activity.
  assign activity  = any_coin || bus.select_valid ||
                     bus.cancel;

  vend_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_tmr (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (!in_credit || activity),
    .en_i    (in_credit),
    .expire_o(expire)
  );

  // Dime wins when both coins arrive together.
  assign cur_w  = wide_t'(credit_q);
  assign coin_w = bus.dime_in   ? wide_t'(DIME)   :
                  bus.nickel_in ? wide_t'(NICKEL) :
                                  '0;
  assign sum_w  = cur_w + coin_w;
  assign coin_ok = any_coin && (sum_w <= MAXW) &&
                   (state_q == IDLE || in_credit);

  assign sel_pr_w  = wide_t'(price_of(bus.item_number));
  assign vend_pr_w = wide_t'(price_of(item_q));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    rej_d    = (bus.nickel_in && bus.dime_in) ||
               (any_coin && !coin_ok);
    disp_d   = 1'b0;
    idisp_d  = '0;
    nout_d   = 1'b0;
    short_d  = 1'b0;
    selerr_d = 1'b0;
    if (coin_ok) credit_d = sum_w[CREDIT_W-1:0];
    unique case (state_q)
      IDLE: begin
        if (coin_ok) state_d = CREDIT;
      end
      CREDIT: begin
        if (bus.cancel) begin
          state_d = CHANGE;
        end else if (bus.select_valid) begin
          if (!is_onehot(bus.item_number)) begin
            selerr_d = 1'b1;
          end else if (cur_w >= sel_pr_w) begin
            item_d  = bus.item_number;
            state_d = VEND;
          end else begin
            short_d = 1'b1;
          end
        end else if (expire) begin
          state_d = CHANGE;
        end
      end
      VEND: begin
        disp_d   = 1'b1;
        idisp_d  = item_q;
        credit_d = credit_q -
                   vend_pr_w[CREDIT_W-1:0];
        state_d  = (cur_w != vend_pr_w) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (bus.hopper_ready) begin
          nout_d   = 1'b1;
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      item_q   <= '0;
      idisp_q  <= '0;
      rej_q    <= 1'b0;
      disp_q   <= 1'b0;
      nout_q   <= 1'b0;
      short_q  <= 1'b0;
      selerr_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      idisp_q  <= idisp_d;
      rej_q    <= rej_d;
      disp_q   <= disp_d;
      nout_q   <= nout_d;
      short_q  <= short_d;
      selerr_q <= selerr_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.coin_reject    = rej_q;
  assign bus.dispense       = disp_q;
  assign bus.item_dispensed = idisp_q;
  assign bus.nickel_out     = nout_q;
  assign bus.price_short    = short_q;
  assign bus.sel_error      = selerr_q;
  assign bus.busy           = busy_q;
  assign bus.credit         = credit_q;

`ifdef VEND_AUDIT_EN
  logic [15:0] sales_q, sales_d;
  logic [16:0] sales_sum;

  assign sales_sum = {1'b0, sales_q} +
                     17'(price_of(item_q));

  always_comb begin
    sales_d = sales_q;
    if (state_q == VEND)
      sales_d = sales_sum[16] ? 16'hFFFF
                              : sales_sum[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sales_q <= '0;
    else       sales_q <= sales_d;
  end

  assign bus.sales_total = sales_q;
`endif

endmodule

// File: tb/tb_vend_txn_controller.sv
// Bench for vend_txn_controller: directed scenarios plus
// random traffic against a transaction-level model.
module tb_vend_txn_controller;

  localparam int CW   = 4;
  localparam int MAXC = 10;
  localparam int TO   = 12;
  localparam int TW   = 4;

  localparam int P_IDLE   = 0;
  localparam int P_CREDIT = 1;
  localparam int P_VEND   = 2;
  localparam int P_CHANGE = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vend_txn_if #(.CREDIT_W(CW)) bus ();

  vend_txn_controller #(
    .CREDIT_W      (CW),
    .MAX_CREDIT    (MAXC),
    .TIMEOUT_CYCLES(TO),
    .TMR_W         (TW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_ph, m_cr, m_tmr, m_sales;
  logic [3:0] m_item;
  logic       e_rej, e_disp, e_nout;
  logic       e_short, e_selerr, e_busy;
  logic [3:0] e_item;

  function automatic int price_tab(input logic [3:0] it);
    for (int i = 0; i < 4; i++)
      if (it[i]) return 3 + i;
    return 0;
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_cr = 0; m_tmr = 0;
    m_sales = 0; m_item = '0;
    e_rej = 0; e_disp = 0; e_nout = 0; e_item = '0;
    e_short = 0; e_selerr = 0; e_busy = 0;
  endtask

  task automatic model_step();
    int  v, ncr, p;
    bit  coin, act;
    coin = bus.nickel_in || bus.dime_in;
    e_rej = 0; e_disp = 0; e_nout = 0; e_item = '0;
    e_short = 0; e_selerr = 0;
    ncr = m_cr;
    if (m_ph == P_IDLE || m_ph == P_CREDIT) begin
      if (bus.nickel_in && bus.dime_in) e_rej = 1;
      if (coin) begin
        v = bus.dime_in ? 2 : 1;
        if (m_cr + v > MAXC) e_rej = 1;
        else ncr = m_cr + v;
      end
    end else if (coin) begin
      e_rej = 1;
    end
    case (m_ph)
      P_IDLE: begin
        m_tmr = 0;
        if (ncr != m_cr) m_ph = P_CREDIT;
      end
      P_CREDIT: begin
        act = coin || bus.select_valid || bus.cancel;
        if (bus.cancel) m_ph = P_CHANGE;
        else if (bus.select_valid) begin
          if ($countones(bus.item_number) != 1)
            e_selerr = 1;
          else begin
            p = price_tab(bus.item_number);
            if (m_cr >= p) begin
              m_item = bus.item_number;
              m_ph   = P_VEND;
            end else e_short = 1;
          end
        end
        if (act) m_tmr = 0;
        else begin
          m_tmr++;
          if (m_tmr == TO) begin
            m_tmr = 0;
            m_ph  = P_CHANGE;
          end
        end
      end
      P_VEND: begin
        m_tmr  = 0;
        p      = price_tab(m_item);
        ncr    = m_cr - p;
        e_disp = 1;
        e_item = m_item;
        m_sales = (m_sales + p > 65535) ? 65535
                                        : m_sales + p;
        m_ph = (ncr > 0) ? P_CHANGE : P_IDLE;
      end
      default: begin
        m_tmr = 0;
        if (bus.hopper_ready && m_cr > 0) begin
          e_nout = 1;
          ncr = m_cr - 1;
        end
        if (ncr == 0) m_ph = P_IDLE;
      end
    endcase
    m_cr   = ncr;
    e_busy = (m_ph == P_VEND) || (m_ph == P_CHANGE);
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- compare + event counters --------
  int         n_nout, n_disp, n_short, n_selerr, n_rej;
  logic [3:0] last_item;

  task automatic clr_cnt();
    n_nout = 0; n_disp = 0; n_short = 0;
    n_selerr = 0; n_rej = 0; last_item = '0;
  endtask

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      chk("coin_reject", 32'(bus.coin_reject), 32'(e_rej));
      chk("dispense", 32'(bus.dispense), 32'(e_disp));
      chk("item_dispensed", 32'(bus.item_dispensed),
          32'(e_item));
      chk("nickel_out", 32'(bus.nickel_out), 32'(e_nout));
      chk("price_short", 32'(bus.price_short),
          32'(e_short));
      chk("sel_error", 32'(bus.sel_error), 32'(e_selerr));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("credit", 32'(bus.credit), m_cr);
`ifdef VEND_AUDIT_EN
      chk("sales_total", 32'(bus.sales_total), m_sales);
`endif
      if (bus.nickel_out)  n_nout++;
      if (bus.price_short) n_short++;
      if (bus.sel_error)   n_selerr++;
      if (bus.coin_reject) n_rej++;
      if (bus.dispense) begin
        n_disp++;
        last_item = bus.item_dispensed;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    bus.nickel_in    = 1'b0;
    bus.dime_in      = 1'b0;
    bus.item_number  = 4'd0;
    bus.select_valid = 1'b0;
    bus.cancel       = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
    idle_in();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic coin(input bit dm);
    if (dm) bus.dime_in = 1'b1;
    else    bus.nickel_in = 1'b1;
    step();
  endtask

  task automatic sel(input logic [3:0] it);
    bus.item_number  = it;
    bus.select_valid = 1'b1;
    step();
  endtask

  task automatic cancel_req();
    bus.cancel = 1'b1;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- main sequence -------------------
  initial begin
    idle_in();
    bus.hopper_ready = 1'b1;
    clr_cnt();
    step();
    step();
    reset = 1'b0;
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_dispense", 32'(bus.dispense), 0);

    // dime, dime, item1: 4 -> 1, one nickel back
    clr_cnt();
    coin(1);
    coin(1);
    chk("t1_credit4", 32'(bus.credit), 4);
    sel(4'b0001);
    idle(6);
    chk("t1_disp", n_disp, 1);
    chk("t1_item", 32'(last_item), 32'h1);
    chk("t1_nout", n_nout, 1);
    chk("t1_credit0", 32'(bus.credit), 0);
    chk("t1_busy", 32'(bus.busy), 0);

    // short credit, then exact price
    clr_cnt();
    coin(0);
    sel(4'b0100);
    idle(2);
    chk("t2_short", n_short, 1);
    chk("t2_credit1", 32'(bus.credit), 1);
    coin(1);
    coin(1);
    sel(4'b0100);
    idle(4);
    chk("t2_disp", n_disp, 1);
    chk("t2_item", 32'(last_item), 32'h4);
    chk("t2_nout", n_nout, 0);
    chk("t2_credit0", 32'(bus.credit), 0);

    // fill to max, reject, cancel with hopper toggling
    clr_cnt();
    repeat (5) coin(1);
    chk("t3_credit10", 32'(bus.credit), 10);
    coin(0);
    idle(1);
    chk("t3_rej", n_rej, 1);
    chk("t3_credit_hold", 32'(bus.credit), 10);
    cancel_req();
    for (int i = 0; i < 30; i++) begin
      bus.hopper_ready = (i % 2 == 0);
      step();
    end
    bus.hopper_ready = 1'b1;
    idle(2);
    chk("t3_nout10", n_nout, 10);
    chk("t3_credit0", 32'(bus.credit), 0);

    // simultaneous coins, then bad selection
    clr_cnt();
    bus.nickel_in = 1'b1;
    bus.dime_in   = 1'b1;
    step();
    chk("t4_credit2", 32'(bus.credit), 2);
    sel(4'b0011);
    idle(2);
    chk("t4_rej", n_rej, 1);
    chk("t4_selerr", n_selerr, 1);
    chk("t4_credit2b", 32'(bus.credit), 2);
    cancel_req();
    idle(4);
    chk("t4_refund", 32'(bus.credit), 0);

    // inactivity refund
    clr_cnt();
    coin(1);
    idle(TO + 4);
    chk("t5_nout2", n_nout, 2);
    chk("t5_credit0", 32'(bus.credit), 0);
    bus.hopper_ready = 1'b0;
    coin(1);
    idle(TO - 1);
    chk("t5_not_yet", 32'(bus.busy), 0);
    idle(1);
    chk("t5_timeout", 32'(bus.busy), 1);
    idle(3);
    chk("t5_stall", 32'(bus.credit), 2);
    reset = 1'b1;
    #1;
    chk("t5_rst_credit", 32'(bus.credit), 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    chk("t5_rst_nout", 32'(bus.nickel_out), 0);
    step();
    step();
    reset = 1'b0;
    bus.hopper_ready = 1'b1;
    idle(3);
    chk("t5_after_rst", 32'(bus.credit), 0);

`ifdef VEND_AUDIT_EN
    do_reset();
    repeat (3) coin(1);
    sel(4'b1000);
    idle(3);
    repeat (3) coin(1);
    sel(4'b1000);
    idle(3);
    chk("t6_sales12", 32'(bus.sales_total), 12);
`endif

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      if ($urandom_range(0, 199) == 0) idle(TO + 2);
      bus.nickel_in    = ($urandom_range(0, 99) < 15);
      bus.dime_in      = ($urandom_range(0, 99) < 15);
      bus.select_valid = ($urandom_range(0, 99) < 10);
      bus.item_number  = $urandom_range(0, 1) ?
                         (4'b0001 << $urandom_range(0, 3)) :
                         4'($urandom_range(0, 15));
      bus.cancel       = ($urandom_range(0, 99) < 2);
      bus.hopper_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    bus.hopper_ready = 1'b1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
Transaction sequencer for the four-item vending machine. It accumulates credit from nickel/dime pulses and accepts a one-hot item selection. It checks credit against the fixed price table, issues a single dispense, then pays change out one nickel at a time through a hopper handshake. It sits above the per-item datapath and replaces per-item credit tracking with one shared credit register, cancel, and inactivity refund.

Parameters:
CREDIT_W, 4, credit register width in nickel units (1 unit = 5 cents)
MAX_CREDIT, 10, maximum credit held in nickels (50 cents); coins that would exceed it are rejected
TIMEOUT_CYCLES, 1000, idle cycles in CREDIT before an automatic refund; must be >= 2
TMR_W, 10, timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
nickel_in  in  1  single-cycle pulse per nickel inserted
dime_in  in  1  single-cycle pulse per dime inserted
item_number  in  4  one-hot selection: bit0=item1 (15c), bit1=item2 (20c), bit2=item3 (25c), bit3=item4 (30c)
select_valid  in  1  item_number is valid this cycle
cancel  in  1  refund request pulse
hopper_ready  in  1  change hopper can accept a nickel_out pulse
coin_reject  out  1  registered pulse; the coin sampled last cycle was not credited
dispense  out  1  registered single-cycle vend strobe
item_dispensed  out  4  one-hot item, valid only while dispense=1, else 0
nickel_out  out  1  registered pulse; one nickel released per pulse
price_short  out  1  registered pulse; selection refused for insufficient credit
sel_error  out  1  registered pulse; select_valid with item_number not one-hot
busy  out  1  high in VEND or CHANGE
credit  out  CREDIT_W  current credit in nickels

Behaviour:
- Reset (async, active-high): state=IDLE, credit=0, timer=0, all outputs 0. Reset mid-CHANGE discards the owed change; this is accepted.
- All outputs are registered. Pulses appear the cycle after the causing input.
- States: IDLE, CREDIT, VEND, CHANGE.
- Coin rule, valid in IDLE and CREDIT only: nickel adds 1 and dime adds 2.
  - If credit+value > MAX_CREDIT: coin is rejected, credit is unchanged, coin_reject=1.
  - nickel_in and dime_in in the same cycle: dime is processed, nickel is rejected.
  - Any coin in VEND or CHANGE is rejected.
- IDLE: an accepted coin moves to CREDIT. select_valid or cancel is ignored (no pulses).
- CREDIT, priority order: cancel > select > timeout.
  - cancel: go to CHANGE (credit retained as change owed).
  - select_valid, not one-hot: sel_error, stay.
  - select_valid, one-hot, pre-coin credit >= PRICE[item]: latch item, go to VEND.
  - select_valid, one-hot, credit too low: price_short, stay.
  - A coin in the same cycle as select is still credited. The price comparison uses pre-coin credit.
  - Timer clears on any coin, select or cancel, otherwise increments. At TIMEOUT_CYCLES it goes to CHANGE.
- VEND, exactly one cycle:
  - dispense=1 and item_dispensed=latched item on the following cycle.
  - credit <= credit - PRICE (never negative, guaranteed by the check).
  - Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE:
  - Each cycle with hopper_ready=1 and credit>0: nickel_out pulse, credit -= 1.
  - When credit reaches 0: go to IDLE.
  - hopper_ready low stalls without limit. select and cancel are ignored.
- Width: credit arithmetic is done at CREDIT_W+1 bits for the overflow compare.

Optional Feature:
VEND_AUDIT_EN:
- Defined: adds output sales_total (16 bits, nickels), a saturating sum of PRICE over every dispense, cleared only by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - state enum
  - NICKEL=1 and DIME=2 unit constants
  - PRICE function/constants (3, 4, 5, 6 nickels)
  - one-hot item codes
  - onehot check function
- One sub-module, vend_timeout_timer: clear/enable/expire counter, parameterised by TIMEOUT_CYCLES.

Test Plan:
- dime, dime, select item_number=0001 -> dispense with item_dispensed=0001, credit 4->1, one nickel_out, then IDLE with credit=0.
- nickel, select 0100 -> price_short pulse, credit stays 1; then dime, dime, select 0100 -> dispense, no nickel_out.
- 5 dimes then nickel -> nickel coin_reject, credit=10; cancel with hopper_ready toggling 1/0 -> exactly 10 nickel_out pulses, none while ready=0.
- nickel_in and dime_in same cycle from IDLE -> credit=2, coin_reject=1; select 0011 -> sel_error, credit unchanged.
- dime, then no activity for TIMEOUT_CYCLES -> CHANGE, 2 nickel_out pulses; reset asserted mid-CHANGE -> all outputs 0, credit=0 immediately.
- With VEND_AUDIT_EN defined: vend item4 twice -> sales_total=12.
